// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
// master drives requests, slave (the FIFO) drives data and status.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             wrEn;
  logic [WIDTH-1:0] wrData;
  logic             rdEn;
  logic             clrErr;
  logic [WIDTH-1:0] rdData;
  logic             rdValid;
  logic             full;
  logic             empty;
  logic             almostFull;
  logic             almostEmpty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wrEn,
    output wrData,
    output rdEn,
    output clrErr,
    input  rdData,
    input  rdValid,
    input  full,
    input  empty,
    input  almostFull,
    input  almostEmpty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  wrEn,
    input  wrData,
    input  rdEn,
    input  clrErr,
    output rdData,
    output rdValid,
    output full,
    output empty,
    output almostFull,
    output almostEmpty,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, thresholds,
// sticky error flags and optional first-word-fall-through read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C   = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_C   = (AW+1)'(AE_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  assign full_w  = (count_q == FULL_C);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wrEn & ~full_w;
  assign rd_acc  = bus.rdEn & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A new error event wins over a same-cycle clear.
  always_comb begin
    ovf_d = (ovf_q & ~bus.clrErr) | (bus.wrEn & full_w);
    unf_d = (unf_q & ~bus.clrErr) | (bus.rdEn & empty_w);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdData  = mem_q[rd_ptr_q];
      assign bus.rdValid = ~empty_w;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_vld_q, rd_vld_d;

      always_comb begin
        rd_data_d = rd_data_q;
        rd_vld_d  = rd_acc;
        if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
          rd_vld_q  <= 1'b0;
        end else begin
          rd_data_q <= rd_data_d;
          rd_vld_q  <= rd_vld_d;
        end
      end

      assign bus.rdData  = rd_data_q;
      assign bus.rdValid = rd_vld_q;
    end
  endgenerate

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostFull  = (count_q >= AF_C);
  assign bus.almostEmpty = (count_q <= AE_C);
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of sync_fifo in standard
// and first-word-fall-through modes.
module tb_sync_fifo;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) fbus ();

  sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) fdut (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wrEn    = 1'b0;
    bus.rdEn    = 1'b0;
    bus.clrErr  = 1'b0;
    bus.wrData  = 8'h00;
    fbus.wrEn   = 1'b0;
    fbus.rdEn   = 1'b0;
    fbus.clrErr = 1'b0;
    fbus.wrData = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.count !== 5'd0) begin
      $display("FAIL reset_count: got %0d exp 0", bus.count);
      errors++;
    end
    checks++;
    if ({bus.empty, bus.full, bus.almostEmpty, bus.almostFull}
        !== 4'b1010) begin
      $display("FAIL reset_flags: got %b exp 1010",
        {bus.empty, bus.full, bus.almostEmpty, bus.almostFull});
      errors++;
    end
    checks++;
    if ({bus.rdValid, bus.overflow, bus.underflow, bus.rdData}
        !== 11'h000) begin
      $display("FAIL reset_out: got %h exp 000",
        {bus.rdValid, bus.overflow, bus.underflow, bus.rdData});
      errors++;
    end
    checks++;
    if ({fbus.rdValid, fbus.empty} !== 2'b01) begin
      $display("FAIL reset_fwft: got %b exp 01",
        {fbus.rdValid, fbus.empty});
      errors++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrData = 8'(i);
      step();
      checks++;
      if (bus.count !== 5'(i + 1)) begin
        $display("FAIL fill_count[%0d]: got %0d exp %0d",
          i, bus.count, i + 1);
        errors++;
      end
      checks++;
      if (bus.almostFull !== ((i + 1) >= 14)) begin
        $display("FAIL fill_af[%0d]: got %b exp %b",
          i, bus.almostFull, (i + 1) >= 14);
        errors++;
      end
      checks++;
      if (bus.almostEmpty !== ((i + 1) <= 2)) begin
        $display("FAIL fill_ae[%0d]: got %b exp %b",
          i, bus.almostEmpty, (i + 1) <= 2);
        errors++;
      end
      checks++;
      if (bus.empty !== 1'b0) begin
        $display("FAIL fill_empty[%0d]: got %b exp 0",
          i, bus.empty);
        errors++;
      end
    end
    checks++;
    if (bus.full !== 1'b1) begin
      $display("FAIL fill_full: got %b exp 1", bus.full);
      errors++;
    end
    bus.wrData = 8'hEE;
    step();
    bus.wrEn = 1'b0;
    checks++;
    if ({bus.overflow, bus.count} !== {1'b1, 5'd16}) begin
      $display("FAIL fill_ovf: got ovf=%b cnt=%0d exp 1/16",
        bus.overflow, bus.count);
      errors++;
    end
  endtask

  task automatic test_drain();
    int pulses;
    pulses = 0;
    bus.clrErr = 1'b1;
    step();
    bus.clrErr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      $display("FAIL drain_clr: got %b exp 0", bus.overflow);
      errors++;
    end
    for (int i = 0; i < 16; i++) begin
      bus.rdEn = 1'b1;
      step();
      if (bus.rdValid === 1'b1) pulses++;
      checks++;
      if (bus.rdData !== 8'(i)) begin
        $display("FAIL drain_data[%0d]: got %h exp %h",
          i, bus.rdData, 8'(i));
        errors++;
      end
      checks++;
      if (bus.count !== 5'(15 - i)) begin
        $display("FAIL drain_count[%0d]: got %0d exp %0d",
          i, bus.count, 15 - i);
        errors++;
      end
    end
    bus.rdEn = 1'b0;
    step();
    checks++;
    if (pulses != 16) begin
      $display("FAIL drain_pulses: got %0d exp 16", pulses);
      errors++;
    end
    checks++;
    if ({bus.rdValid, bus.empty, bus.rdData} !== {2'b01, 8'h0F}) begin
      $display("FAIL drain_idle: got v=%b e=%b d=%h exp 0/1/0f",
        bus.rdValid, bus.empty, bus.rdData);
      errors++;
    end
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
    checks++;
    if ({bus.underflow, bus.rdValid, bus.rdData}
        !== {2'b10, 8'h0F}) begin
      $display("FAIL drain_unf: got u=%b v=%b d=%h exp 1/0/0f",
        bus.underflow, bus.rdValid, bus.rdData);
      errors++;
    end
    bus.clrErr = 1'b1;
    step();
    bus.clrErr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrData = 8'h40 + 8'(i);
      q.push_back(bus.wrData);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      bus.wrEn   = 1'b1;
      bus.rdEn   = 1'b1;
      bus.wrData = 8'h48 + 8'(i);
      q.push_back(bus.wrData);
      exp = q.pop_front();
      step();
      checks++;
      if ({bus.rdValid, bus.rdData, bus.count}
          !== {1'b1, exp, 5'd8}) begin
        $display("FAIL b2b[%0d]: got v=%b d=%h c=%0d exp 1/%h/8",
          i, bus.rdValid, bus.rdData, bus.count, exp);
        errors++;
      end
    end
    bus.wrEn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rdEn = 1'b1;
      exp = q.pop_front();
      step();
      checks++;
      if (bus.rdData !== exp) begin
        $display("FAIL b2b_tail[%0d]: got %h exp %h",
          i, bus.rdData, exp);
        errors++;
      end
    end
    bus.rdEn = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      $display("FAIL b2b_empty: got %b exp 1", bus.empty);
      errors++;
    end
  endtask

  task automatic test_full_empty();
    for (int i = 0; i < 16; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrData = 8'h80 + 8'(i);
      step();
    end
    bus.rdEn   = 1'b1;
    bus.wrData = 8'hFF;
    step();
    bus.wrEn = 1'b0;
    checks++;
    if ({bus.count, bus.overflow, bus.rdValid, bus.rdData}
        !== {5'd15, 2'b11, 8'h80}) begin
      $display("FAIL fe_full: got c=%0d o=%b v=%b d=%h exp 15/1/1/80",
        bus.count, bus.overflow, bus.rdValid, bus.rdData);
      errors++;
    end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if ({bus.rdData, bus.empty} !== {8'h8F, 1'b1}) begin
      $display("FAIL fe_last: got d=%h e=%b exp 8f/1",
        bus.rdData, bus.empty);
      errors++;
    end
    bus.wrEn   = 1'b1;
    bus.wrData = 8'h33;
    step();
    bus.wrEn = 1'b0;
    bus.rdEn = 1'b0;
    checks++;
    if ({bus.count, bus.underflow, bus.rdValid}
        !== {5'd1, 2'b10}) begin
      $display("FAIL fe_empty: got c=%0d u=%b v=%b exp 1/1/0",
        bus.count, bus.underflow, bus.rdValid);
      errors++;
    end
    bus.clrErr = 1'b1;
    step();
    bus.clrErr = 1'b0;
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      $display("FAIL fe_clr: got %b exp 00",
        {bus.overflow, bus.underflow});
      errors++;
    end
    bus.rdEn = 1'b1;
    step();
    checks++;
    if (bus.rdData !== 8'h33) begin
      $display("FAIL fe_word: got %h exp 33", bus.rdData);
      errors++;
    end
    bus.clrErr = 1'b1;
    step();
    bus.rdEn   = 1'b0;
    bus.clrErr = 1'b0;
    checks++;
    if (bus.underflow !== 1'b1) begin
      $display("FAIL fe_prio: got %b exp 1", bus.underflow);
      errors++;
    end
    bus.clrErr = 1'b1;
    step();
    bus.clrErr = 1'b0;
  endtask

  task automatic test_fwft();
    fbus.wrEn   = 1'b1;
    fbus.wrData = 8'hA5;
    step();
    fbus.wrEn = 1'b0;
    checks++;
    if ({fbus.rdValid, fbus.rdData, fbus.count}
        !== {1'b1, 8'hA5, 5'd1}) begin
      $display("FAIL fwft_show: got v=%b d=%h c=%0d exp 1/a5/1",
        fbus.rdValid, fbus.rdData, fbus.count);
      errors++;
    end
    fbus.rdEn = 1'b1;
    step();
    fbus.rdEn = 1'b0;
    checks++;
    if ({fbus.rdValid, fbus.empty} !== 2'b01) begin
      $display("FAIL fwft_pop: got v=%b e=%b exp 0/1",
        fbus.rdValid, fbus.empty);
      errors++;
    end
    fbus.wrEn   = 1'b1;
    fbus.wrData = 8'hB1;
    step();
    fbus.wrData = 8'hB2;
    step();
    fbus.wrEn = 1'b0;
    fbus.rdEn = 1'b1;
    step();
    fbus.rdEn = 1'b0;
    checks++;
    if ({fbus.rdValid, fbus.rdData} !== {1'b1, 8'hB2}) begin
      $display("FAIL fwft_next: got v=%b d=%h exp 1/b2",
        fbus.rdValid, fbus.rdData);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrData = 8'h10 + 8'(i);
      step();
    end
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
    checks++;
    if (bus.count !== 5'd9) begin
      $display("FAIL ar_pre: got %0d exp 9", bus.count);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.almostEmpty,
         bus.almostFull, bus.rdValid, bus.rdData}
        !== {5'd0, 5'b10100, 8'h00}) begin
      $display("FAIL ar_mid: got c=%0d e=%b f=%b v=%b d=%h",
        bus.count, bus.empty, bus.full, bus.rdValid, bus.rdData);
      errors++;
    end
    idle();
    step();
    rst = 1'b0;
    step();
    bus.wrEn   = 1'b1;
    bus.wrData = 8'h5A;
    step();
    bus.wrEn = 1'b0;
    checks++;
    if (bus.count !== 5'd1) begin
      $display("FAIL ar_wr: got %0d exp 1", bus.count);
      errors++;
    end
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
    checks++;
    if ({bus.rdData, bus.empty} !== {8'h5A, 1'b1}) begin
      $display("FAIL ar_rd: got d=%h e=%b exp 5a/1",
        bus.rdData, bus.empty);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty();
    test_fwft();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: storage, pointers and status logic in one block, for buffering byte or word streams between producer and consumer stages in the same clock domain. Adds configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through read mode.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AW, $clog2(DEPTH), pointer/address width (derived; not overridden)
- AF_TH, DEPTH-2, almostFull asserted when count ≥ AF_TH (1..DEPTH)
- AE_TH, 2, almostEmpty asserted when count ≤ AE_TH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wrEn  in  1  write request
- wrData  in  WIDTH  write data, sampled with wrEn
- rdEn  in  1  read request (FWFT: pop/acknowledge head word)
- rdData  out  WIDTH  read data
- rdValid  out  1  rdData holds a valid popped/head word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almostFull  out  1  count ≥ AF_TH
- almostEmpty  out  1  count ≤ AE_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clrErr  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH × WIDTH register array; wrPtr, rdPtr are AW bits and wrap DEPTH-1 → 0 naturally; count is a separate AW+1-bit register.
- Write accepted iff wrEn && !full (full as registered at that edge): mem[wrPtr] ← wrData, wrPtr+1.
- Read accepted iff rdEn && !empty: rdPtr+1.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Full + wrEn + rdEn: read accepted, write rejected, overflow set; count goes DEPTH → DEPTH−1.
- Empty + wrEn + rdEn: write accepted, read rejected, underflow set; count 0 → 1 (no bypass).
- Rejected accesses change no data, pointer or count.
- overflow set on wrEn && full; underflow set on rdEn && empty; both hold until clrErr or rst. Set has priority over clrErr in the same cycle.
- full, empty, almostFull, almostEmpty are combinational decodes of the count register only.
- Standard mode (FWFT=0): accepted read loads rdData ← mem[rdPtr] at that edge; rdValid is a one-cycle pulse registered on the same edge; rdData holds its value otherwise.
- FWFT mode (FWFT=1): rdData = mem[rdPtr] combinationally; rdValid = !empty; rdEn consumes the displayed word.
- Reset (asynchronous, any time, including mid-burst): pointers, count, rdData, rdValid, overflow, underflow → 0; empty=1, full=0, almostEmpty=1, almostFull=0. Array contents are not cleared and are unobservable until rewritten.

## Timing
- Write-to-visible: word written at edge N; count/empty update after edge N. Standard mode: earliest rdEn at edge N+1, rdData valid after N+1. FWFT: rdData valid immediately after edge N.
- Read latency (standard): 1 cycle, from rdEn edge to rdData/rdValid.
- Sustained throughput: one write and one read per cycle at any occupancy 1..DEPTH−1.
- Flags change only at clk edges or on rst assertion; no combinational path from wrEn/rdEn to any output.

## Test plan
- Reset then fill: DEPTH=16, write 0x00..0x0F on 16 cycles -> count=16, full=1, almostFull from count=14, empty=0 after first write; 17th write sets overflow, count stays 16.
- Drain in order (standard): 16 rdEn cycles -> rdData 0x00..0x0F, each 1 cycle after its rdEn, rdValid pulses 16 times; then empty=1; extra rdEn sets underflow, rdData keeps 0x0F.
- Wrap and concurrency: hold count=8, drive wrEn+rdEn for 40 cycles -> count stays 8, output sequence exactly matches input across pointer wrap.
- Full/empty simultaneous: at full assert wrEn+rdEn -> count=15, overflow=1, head popped; at empty assert both -> count=1, underflow=1; clrErr then clears both flags.
- FWFT=1: write 0xA5 -> next cycle rdData=0xA5, rdValid=1 with no rdEn; rdEn pops -> rdValid=0 and empty=1.
- Async reset mid-burst: assert rst between edges at count=9 -> all outputs reach reset values before the next edge; following write/read returns the new data only.
